// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: fixed display prefetch slots from the VGA counters,
// a req/ack draw port, and a clear sweep that fills the remaining free slots.
module vga_fb_arbiter #(
    parameter int                 FB_W        = 160,
    parameter int                 FB_H        = 120,
    parameter int                 COLOR_W     = 12,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = 12'h000,
    parameter int                 H_VISIBLE   = 640,
    parameter int                 V_VISIBLE   = 480,
    parameter int                 H_TOTAL     = 800,
    parameter int                 V_TOTAL     = 525
) (
    input  logic               clk_25mhz,
    input  logic               reset,
    input  logic [9:0]         h_cnt,
    input  logic [9:0]         v_cnt,
    input  logic               video_on,
    input  logic               wr_req,
    input  logic [7:0]         wr_x,
    input  logic [6:0]         wr_y,
    input  logic [COLOR_W-1:0] wr_data,
    output logic               wr_ack,
    input  logic               clear_req,
    output logic               clear_busy,
    output logic               clear_done,
    output logic [14:0]        mem_addr,
    output logic               mem_we,
    output logic [COLOR_W-1:0] mem_wdata,
    input  logic [COLOR_W-1:0] mem_rdata,
    output logic [COLOR_W-1:0] pixel_rgb
);

    localparam logic [9:0]  H_FETCH_END = 10'(H_VISIBLE - 2);
    localparam logic [9:0]  H_PREFETCH  = 10'(H_TOTAL - 2);
    localparam logic [9:0]  V_VIS       = 10'(V_VISIBLE);
    localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [14:0] LAST_ADDR   = 15'(FB_W * FB_H - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    function automatic logic [14:0] fb_addr(input logic [7:0] x, input logic [7:0] y);
        fb_addr = (15'(y) * 15'(FB_W)) + 15'(x);
    endfunction

    state_e             state_q, state_d;
    logic [14:0]        clr_addr_q, clr_addr_d;
    logic               wr_ack_q, wr_ack_d;
    logic               clr_busy_q, clr_busy_d;
    logic               clr_done_q, clr_done_d;
    logic [COLOR_W-1:0] pix_q, pix_d;

    logic [9:0]         v_next_s;
    logic               fetch_vis_s;
    logic               fetch_pre_s;
    logic               display_s;
    logic [14:0]        disp_addr_s;
    logic               in_range_s;
    logic               mem_we_s;
    logic [14:0]        mem_addr_s;
    logic [COLOR_W-1:0] mem_wdata_s;

    // Display slot decode: one fetch per 4-pixel column (one column ahead) plus the next line's first column at h=798.
    always_comb begin
        v_next_s    = v_cnt + 10'd1;
        fetch_vis_s = (h_cnt[1:0] == 2'd2) && (h_cnt < H_FETCH_END) && (v_cnt < V_VIS);
        fetch_pre_s = (h_cnt == H_PREFETCH) && ((v_next_s < V_VIS) || (v_cnt == V_LAST));
        display_s   = fetch_vis_s || fetch_pre_s;
        if (fetch_vis_s) begin
            disp_addr_s = fb_addr(h_cnt[9:2] + 8'd1, v_cnt[9:2]);
        end else if (v_cnt == V_LAST) begin
            disp_addr_s = 15'd0;
        end else begin
            disp_addr_s = fb_addr(8'd0, v_next_s[9:2]);
        end
    end

    assign in_range_s = (wr_x < 8'(FB_W)) && (wr_y < 7'(FB_H));

    // Slot arbitration and next-state logic; display always wins, free slots go to clear or draw.
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        clr_busy_d  = clr_busy_q;
        clr_done_d  = 1'b0;
        wr_ack_d    = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = disp_addr_s;
        mem_wdata_s = wr_data;

        if (h_cnt[1:0] == 2'b11) begin
            pix_d = mem_rdata;
        end else begin
            pix_d = pix_q;
        end

        if (display_s) begin
            mem_we_s   = 1'b0;
            mem_addr_s = disp_addr_s;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // No acceptance during the ack cycle: the requester is still retiring the previous one.
                    if (wr_req && !wr_ack_q) begin
                        wr_ack_d   = 1'b1;
                        mem_addr_s = fb_addr(wr_x, {1'b0, wr_y});
                        mem_we_s   = in_range_s;
                    end else begin
                        mem_we_s = 1'b0;
                    end
                end
                ST_CLEAR: begin
                    mem_we_s    = 1'b1;
                    mem_addr_s  = clr_addr_q;
                    mem_wdata_s = CLEAR_COLOR;
                    if (clr_addr_q == LAST_ADDR) begin
                        state_d    = ST_IDLE;
                        clr_busy_d = 1'b0;
                        clr_done_d = 1'b1;
                    end else begin
                        clr_addr_d = clr_addr_q + 15'd1;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    mem_we_s = 1'b0;
                end
            endcase
        end

        if ((state_q == ST_IDLE) && clear_req) begin
            state_d    = ST_CLEAR;
            clr_addr_d = 15'd0;
            clr_busy_d = 1'b1;
        end else begin
            state_d = state_d;
        end

        if (reset) begin
            mem_we_s = 1'b0;
        end else begin
            mem_we_s = mem_we_s;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            clr_addr_q <= 15'd0;
            wr_ack_q   <= 1'b0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
            pix_q      <= {COLOR_W{1'b0}};
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            wr_ack_q   <= wr_ack_d;
            clr_busy_q <= clr_busy_d;
            clr_done_q <= clr_done_d;
            pix_q      <= pix_d;
        end
    end

    assign wr_ack     = wr_ack_q;
    assign clear_busy = clr_busy_q;
    assign clear_done = clr_done_q;
    assign mem_addr   = mem_addr_s;
    assign mem_we     = mem_we_s;
    assign mem_wdata  = mem_wdata_s;
    assign pixel_rgb  = video_on ? pix_q : {COLOR_W{1'b0}};

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: behavioural RAM, cycle-level reference model of the
// slot/handshake/clear rules, directed scenarios and randomized draw traffic.
module tb_vga_fb_arbiter;

    localparam int FB_W    = 160;
    localparam int FB_H    = 120;
    localparam int FB_SIZE = FB_W * FB_H;

    logic        clk_25mhz = 1'b0;
    logic        reset;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        video_on;
    logic        wr_req;
    logic [7:0]  wr_x;
    logic [6:0]  wr_y;
    logic [11:0] wr_data;
    logic        wr_ack;
    logic        clear_req;
    logic        clear_busy;
    logic        clear_done;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic [11:0] pixel_rgb;

    logic [11:0] ram [0:32767];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;
    bit rand_req = 1'b0;

    // Reference model state
    bit          m_ack       = 1'b0;
    bit          m_busy      = 1'b0;
    bit          m_done      = 1'b0;
    int          m_caddr     = 0;
    logic [11:0] m_pix       = 12'h000;
    bit          m_pix_known = 1'b0;
    bit          prev_known  = 1'b0;
    logic [11:0] prev_val    = 12'h000;
    int          md;
    bit          m_acc;
    bit          m_exp_we;
    int          m_exp_addr;
    logic [11:0] m_exp_wd;

    vga_fb_arbiter dut (
        .clk_25mhz  (clk_25mhz),
        .reset      (reset),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .video_on   (video_on),
        .wr_req     (wr_req),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .pixel_rgb  (pixel_rgb)
    );

    always #5 clk_25mhz = ~clk_25mhz;

    // Single-port RAM, read-first, one-cycle read latency
    always @(posedge clk_25mhz) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Framebuffer address fetched in this cycle, or -1 when the slot is free
    function automatic int disp_addr(input int h, input int v);
        if ((h % 4) == 2 && h < 638 && v < 480) return (v / 4) * FB_W + (h / 4) + 1;
        if (h == 798) begin
            if (v + 1 < 480) return ((v + 1) / 4) * FB_W;
            if (v == 524) return 0;
        end
        return -1;
    endfunction

    task automatic set_pos(input int h, input int v);
        h_cnt    = 10'(h);
        v_cnt    = 10'(v);
        video_on = (h < 640) && (v < 480);
    endtask

    task automatic drive_req();
        if (wr_req && wr_ack) wr_req = 1'b0;
        if (rand_req && !wr_req && $urandom_range(0, 3) == 0) begin
            wr_req  = 1'b1;
            wr_x    = 8'($urandom_range(0, 170));
            wr_y    = 7'($urandom_range(0, 127));
            wr_data = 12'($urandom);
        end
        chk_en = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk_25mhz);
        #1;
        if (h_cnt == 10'd799) set_pos(0, (v_cnt == 10'd524) ? 0 : int'(v_cnt) + 1);
        else set_pos(int'(h_cnt) + 1, int'(v_cnt));
        drive_req();
    endtask

    task automatic jump(input int h, input int v);
        @(posedge clk_25mhz);
        #1;
        set_pos(h, v);
        drive_req();
    endtask

    // Reference model: predict this cycle's outputs, compare, then advance
    always @(negedge clk_25mhz) begin
        if (chk_en) begin
            md         = disp_addr(int'(h_cnt), int'(v_cnt));
            m_acc      = 1'b0;
            m_exp_we   = 1'b0;
            m_exp_addr = md;
            m_exp_wd   = 12'h000;
            if (md < 0 && !reset) begin
                if (m_busy) begin
                    m_exp_we   = 1'b1;
                    m_exp_addr = m_caddr;
                end else if (wr_req && !m_ack) begin
                    m_acc      = 1'b1;
                    m_exp_we   = (int'(wr_x) < FB_W) && (int'(wr_y) < FB_H);
                    m_exp_addr = int'(wr_y) * FB_W + int'(wr_x);
                    m_exp_wd   = wr_data;
                end
            end
            check_eq("m_we", mem_we, m_exp_we);
            if (md >= 0 || m_exp_we) check_eq("m_addr", mem_addr, m_exp_addr);
            if (m_exp_we) check_eq("m_wdata", mem_wdata, m_exp_wd);
            check_eq("m_ack", wr_ack, m_ack);
            check_eq("m_busy", clear_busy, m_busy);
            check_eq("m_done", clear_done, m_done);
            if (!video_on) check_eq("m_pix_blank", pixel_rgb, 12'h000);
            else if (m_pix_known) check_eq("m_pix", pixel_rgb, m_pix);

            if (reset) begin
                m_ack       = 1'b0;
                m_busy      = 1'b0;
                m_done      = 1'b0;
                m_caddr     = 0;
                m_pix       = 12'h000;
                m_pix_known = 1'b1;
            end else begin
                m_ack  = m_acc;
                m_done = 1'b0;
                if (m_busy) begin
                    if (md < 0) begin
                        if (m_caddr == FB_SIZE - 1) begin
                            m_busy = 1'b0;
                            m_done = 1'b1;
                        end else begin
                            m_caddr++;
                        end
                    end
                end else if (clear_req) begin
                    m_busy  = 1'b1;
                    m_caddr = 0;
                end
                if (h_cnt[1:0] == 2'b11) begin
                    m_pix       = prev_val;
                    m_pix_known = prev_known;
                end
            end
            prev_known = (md >= 0);
            prev_val   = (md >= 0) ? ram[md] : 12'h000;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int cyc;
        int acks;
        int dones;

        reset     = 1'b1;
        clear_req = 1'b0;
        wr_req    = 1'b1;
        wr_x      = 8'd5;
        wr_y      = 7'd3;
        wr_data   = 12'h111;
        set_pos(200, 100);
        for (int i = 0; i < 32768; i++) ram[i] <= 12'(i);

        // Reset mid-frame with a pending draw: no write, no ack
        for (int i = 0; i < 3; i++) begin
            tick();
            #2;
            check_eq("rst_we", mem_we, 1'b0);
            check_eq("rst_ack", wr_ack, 1'b0);
            check_eq("rst_busy", clear_busy, 1'b0);
            check_eq("rst_done", clear_done, 1'b0);
            check_eq("rst_pix", pixel_rgb, 12'h000);
        end
        reset  = 1'b0;
        wr_req = 1'b0;

        // Scan-out of row 0 with RAM[x] = x
        jump(790, 524);
        cyc = 0;
        while (!(v_cnt == 10'd0 && h_cnt == 10'd700) && cyc < 2000) begin
            tick();
            cyc++;
            #2;
            if (v_cnt == 10'd0) begin
                case (h_cnt)
                    10'd1:   check_eq("scan_pix_h1", pixel_rgb, 12'd0);
                    10'd2:   check_eq("scan_addr_h2", mem_addr, 15'd1);
                    10'd5:   check_eq("scan_pix_h5", pixel_rgb, 12'd1);
                    10'd6:   check_eq("scan_addr_h6", mem_addr, 15'd2);
                    10'd9:   check_eq("scan_pix_h9", pixel_rgb, 12'd2);
                    10'd645: check_eq("scan_pix_h645", pixel_rgb, 12'd0);
                    default: ;
                endcase
            end
        end

        // Draw in a free slot
        jump(100, 10);
        wr_req  = 1'b1;
        wr_x    = 8'd5;
        wr_y    = 7'd3;
        wr_data = 12'hABC;
        #2;
        check_eq("draw_we", mem_we, 1'b1);
        check_eq("draw_addr", mem_addr, 15'd485);
        check_eq("draw_wdata", mem_wdata, 12'hABC);
        tick(); #2;
        check_eq("draw_ack", wr_ack, 1'b1);
        tick(); #2;
        check_eq("draw_ack_one", wr_ack, 1'b0);

        // Draw arriving in a display slot waits one cycle
        jump(102, 10);
        wr_req  = 1'b1;
        wr_x    = 8'd7;
        wr_y    = 7'd2;
        wr_data = 12'h123;
        #2;
        check_eq("wait_we_102", mem_we, 1'b0);
        tick(); #2;
        check_eq("wait_we_103", mem_we, 1'b1);
        check_eq("wait_addr_103", mem_addr, 15'd327);
        tick(); #2;
        check_eq("wait_ack_104", wr_ack, 1'b1);

        // Out-of-range draw is dropped but acked once
        jump(200, 10);
        wr_req  = 1'b1;
        wr_x    = 8'd160;
        wr_y    = 7'd0;
        wr_data = 12'hFFF;
        acks    = 0;
        for (int i = 0; i < 8; i++) begin
            #2;
            check_eq("oor_we", mem_we, 1'b0);
            if (wr_ack) acks++;
            tick();
        end
        check_eq("oor_acks", acks, 1);

        // Full clear with a draw held throughout
        jump(0, 470);
        clear_req = 1'b1;
        #2;
        tick();
        clear_req = 1'b0;
        wr_req    = 1'b1;
        wr_x      = 8'd1;
        wr_y      = 7'd1;
        wr_data   = 12'h555;
        n = 0; acks = 0; cyc = 0;
        while (!clear_done && cyc < 40000) begin
            #2;
            if (mem_we) begin
                check_eq("clr_addr", mem_addr, n);
                check_eq("clr_wdata", mem_wdata, 12'h000);
                n++;
            end
            if (wr_ack) acks++;
            tick();
            cyc++;
        end
        check_eq("clr_done_seen", clear_done, 1'b1);
        check_eq("clr_busy_drop", clear_busy, 1'b0);
        check_eq("clr_writes", n, FB_SIZE);
        check_eq("clr_no_ack", acks, 0);
        dones = 0; acks = 0;
        for (int i = 0; i < 20; i++) begin
            tick(); #2;
            if (clear_done) dones++;
            if (wr_ack) acks++;
        end
        check_eq("clr_done_once", dones, 0);
        check_eq("clr_held_ack", acks, 1);

        // Reset partway through a clear aborts it; next clear restarts at 0
        jump(0, 100);
        clear_req = 1'b1;
        #2;
        tick();
        clear_req = 1'b0;
        n = 0; cyc = 0;
        while (n < 5000 && cyc < 10000) begin
            #2;
            if (clear_busy && mem_we) begin
                check_eq("clr2_addr", mem_addr, n);
                n++;
            end
            tick();
            cyc++;
        end
        check_eq("clr2_progress", n, 5000);
        reset = 1'b1;
        #2;
        check_eq("clr2_rst_we", mem_we, 1'b0);
        tick(); #2;
        check_eq("clr2_rst_we2", mem_we, 1'b0);
        tick();
        reset = 1'b0;
        #2;
        check_eq("clr2_busy_off", clear_busy, 1'b0);
        dones = 0;
        for (int i = 0; i < 200; i++) begin
            tick(); #2;
            if (clear_done) dones++;
        end
        check_eq("clr2_no_done", dones, 0);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        n = -1;
        for (int i = 0; i < 20 && n < 0; i++) begin
            #2;
            if (clear_busy && mem_we) n = int'(mem_addr);
            tick();
        end
        check_eq("clr3_restart", n, 0);
        cyc = 0;
        while (!clear_done && cyc < 40000) begin
            tick();
            cyc++;
        end
        check_eq("clr3_done", clear_done, 1'b1);

        // Randomized draw traffic over random screen positions
        rand_req = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 199) == 0) jump($urandom_range(0, 799), $urandom_range(0, 524));
            else tick();
        end
        rand_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
Owns the single-port framebuffer RAM that feeds the VGA scan-out. It shares the RAM between two users: display prefetch, which has fixed time slots derived from h_cnt/v_cnt, and the analytics drawing port, which uses a req/ack handshake. A built-in clear sequencer sweeps the whole buffer using free slots. The framebuffer is 160x120 and is shown at 640x480 with 4x4 pixel replication.

Parameters:
FB_W, 160, framebuffer width in pixels
FB_H, 120, framebuffer height in pixels
COLOR_W, 12, pixel colour width (RGB444)
CLEAR_COLOR, 12'h000, value written by the clear sequencer
H_VISIBLE, 640, visible columns of the timing generator
V_VISIBLE, 480, visible lines
H_TOTAL, 800, columns per line
V_TOTAL, 525, lines per frame

Ports:
clk_25mhz  in  1  pixel clock
reset  in  1  synchronous, active-high reset
h_cnt  in  10  horizontal counter from the timing generator (0..H_TOTAL-1)
v_cnt  in  10  vertical counter (0..V_TOTAL-1)
video_on  in  1  visible-area flag from the timing generator
wr_req  in  1  draw request; held until wr_ack
wr_x  in  8  draw column
wr_y  in  7  draw row
wr_data  in  COLOR_W  draw colour
wr_ack  out  1  one-cycle pulse: request retired
clear_req  in  1  start full-buffer clear
clear_busy  out  1  clear sweep in progress
clear_done  out  1  one-cycle pulse after the last clear write
mem_addr  out  15  RAM address, y*FB_W+x
mem_we  out  1  RAM write enable
mem_wdata  out  COLOR_W  RAM write data
mem_rdata  in  COLOR_W  RAM read data, 1-cycle synchronous latency
pixel_rgb  out  COLOR_W  colour to the DAC

Behaviour:
- Reset (sampled high at a clock edge): state=IDLE, wr_ack=0, clear_busy=0, clear_done=0, pixel register=0, clear address=0. While reset is high, mem_we is forced to 0. A reset mid-clear aborts the sweep and does not pulse clear_done.
- mem_addr, mem_we and mem_wdata are combinational from state, counters and requests. The RAM registers them.
- Display slots (read, mem_we=0), highest priority:
  - h_cnt[1:0]==2 and h_cnt<638 and v_cnt<V_VISIBLE: addr=(v_cnt>>2)*FB_W+(h_cnt>>2)+1.
  - h_cnt==798: addr=row*FB_W+0, where row=(v_cnt+1)>>2 if v_cnt+1<V_VISIBLE, row=0 if v_cnt==V_TOTAL-1, and otherwise the slot is free.
- Pixel register loads mem_rdata at the clock edge ending each cycle with h_cnt[1:0]==3 (display data then covers h_cnt 4k..4k+3). pixel_rgb = pixel register when video_on, else 0.
- Every non-display cycle is a free slot.
- State IDLE:
  - In a free slot with wr_req=1: if wr_x<FB_W and wr_y<FB_H, drive mem_we=1, addr=wr_y*FB_W+wr_x, wdata=wr_data.
  - Out-of-range requests are retired with mem_we=0 (dropped).
  - wr_ack is registered and goes high the following cycle for exactly one cycle. The requester must deassert wr_req or present a new request in the ack cycle; no write is accepted in the ack cycle.
  - A wr_req arriving in a display slot waits. Worst-case wait is 1 cycle during visible lines.
  - clear_req=1: go to CLEAR next cycle, clear address=0, clear_busy=1. A write committed in that same cycle completes normally.
- State CLEAR:
  - Each free slot writes CLEAR_COLOR at the clear address, then increments it.
  - The write with address FB_W*FB_H-1 returns to IDLE; clear_done pulses in the next cycle and clear_busy drops with it.
  - wr_req is stalled with no ack. clear_req is ignored.
- Address arithmetic is 15-bit unsigned. No wrap beyond FB_W*FB_H-1.

Test Plan:
- Assert reset for 3 cycles mid-frame -> wr_ack=0, clear_busy=0, clear_done=0, pixel_rgb=0, and mem_we=0 for every reset cycle.
- Preload RAM[x]=x for row 0, run v_cnt=0 -> mem_addr=1 at h_cnt=2 and 2 at h_cnt=6; pixel_rgb=0 at h_cnt 0..3 (from the fetch at h_cnt=798 of v_cnt=524), 1 at 4..7, 2 at 8..11; pixel_rgb=0 when h_cnt>=640.
- wr_req with x=5, y=3, data=12'hABC at h_cnt=100 (free) -> mem_we=1, mem_addr=485 that cycle; wr_ack=1 at h_cnt=101 only.
- wr_req at h_cnt=102, v_cnt=10 (display slot) -> mem_we=0 at 102; write at 103; wr_ack at 104.
- wr_x=160, wr_y=0 -> no mem_we at any point, wr_ack pulses once.
- clear_req, with wr_req held during CLEAR -> exactly 19200 mem_we pulses with wdata=CLEAR_COLOR at addresses 0..19199 in order; no wr_ack until after clear_done; clear_done pulses once.
- Reset at clear address 5000 -> no clear_done; the next clear_req restarts at address 0.
